// File: rtl/term_loopback_cfg.sv
// Edge terminator tile: loops S_END back out as N_BEG under per-channel,
// frame-loaded mode bits, and forwards the frame/clock chain unchanged.
module term_loopback_cfg #(
    parameter int NUM_CH          = 52,
    parameter int PIPE_DEPTH      = 2,
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32
) (
    input  logic                       UserCLK,
    input  logic                       resetn,
    input  logic [NUM_CH-1:0]          S_END,
    output logic [NUM_CH-1:0]          N_BEG,
    input  logic [FrameBitsPerRow-1:0] FrameData,
    output logic [FrameBitsPerRow-1:0] FrameData_O,
    input  logic [MaxFramesPerCol-1:0] FrameStrobe,
    output logic [MaxFramesPerCol-1:0] FrameStrobe_O,
    output logic                       UserCLKo
);

    localparam int NUM_FRAMES = (2 * NUM_CH + FrameBitsPerRow - 1) / FrameBitsPerRow;
    localparam int CFG_BITS   = NUM_FRAMES * FrameBitsPerRow;
    localparam int USED_BITS  = 2 * NUM_CH;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'b00,
        MODE_DIRECT = 2'b01,
        MODE_PIPE   = 2'b10,
        MODE_HIGH   = 2'b11
    } mode_e;

    if (PIPE_DEPTH < 1 || PIPE_DEPTH > 4) begin : g_bad_depth
        $error("term_loopback_cfg: PIPE_DEPTH must be in 1..4");
    end

    if (NUM_FRAMES > MaxFramesPerCol) begin : g_bad_frames
        $error("term_loopback_cfg: NUM_FRAMES exceeds MaxFramesPerCol");
    end

    // Chain pass-through; deliberately untouched by reset.
    assign FrameData_O   = FrameData;
    assign FrameStrobe_O = FrameStrobe;
    assign UserCLKo      = UserCLK;

    logic [FrameBitsPerRow-1:0] frame_q [NUM_FRAMES];
    logic [CFG_BITS-1:0]        cfg_w;

    for (genvar f = 0; f < NUM_FRAMES; f++) begin : g_frame
        // Frame f captures FrameData whenever its strobe is high.
        always_ff @(posedge UserCLK or negedge resetn) begin
            if (!resetn) begin
                frame_q[f] <= '0;
            end else if (FrameStrobe[f]) begin
                frame_q[f] <= FrameData;
            end
        end
        assign cfg_w[f*FrameBitsPerRow +: FrameBitsPerRow] = frame_q[f];
    end

    // Padding bits of the last frame are stored but drive nothing.
    if (CFG_BITS > USED_BITS) begin : g_spare
        logic unused_spare;
        assign unused_spare = ^cfg_w[CFG_BITS-1:USED_BITS];
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [PIPE_DEPTH-1:0] pipe_q;
        logic [PIPE_DEPTH-1:0] pipe_d;
        mode_e                 mode;
        logic                  nbeg_w;

        assign mode      = mode_e'(cfg_w[2*c +: 2]);
        assign pipe_d[0] = S_END[c];
        for (genvar k = 1; k < PIPE_DEPTH; k++) begin : g_shift
            assign pipe_d[k] = pipe_q[k-1];
        end

        // History shifts every cycle in every mode so a switch to
        // registered mode shows real past samples immediately.
        always_ff @(posedge UserCLK or negedge resetn) begin
            if (!resetn) begin
                pipe_q <= '0;
            end else begin
                pipe_q <= pipe_d;
            end
        end

        // Output select reads the config flops directly (no extra latency).
        always_comb begin
            nbeg_w = 1'b0;
            case (mode)
                MODE_OFF:    nbeg_w = 1'b0;
                MODE_DIRECT: nbeg_w = S_END[c];
                MODE_PIPE:   nbeg_w = pipe_q[PIPE_DEPTH-1];
                MODE_HIGH:   nbeg_w = 1'b1;
                default:     nbeg_w = 1'b0;
            endcase
        end

        assign N_BEG[c] = nbeg_w;
    end

endmodule

// File: tb/tb_term_loopback_cfg.sv
// Self-checking bench: two instances (PIPE_DEPTH 2 and 4) share all inputs
// and are compared against a frame/history reference model.
module tb_term_loopback_cfg;

    localparam int NUM_CH = 52;
    localparam int NF     = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic [51:0] s_end;
    logic [31:0] fdata;
    logic [19:0] fstb;
    logic [51:0] nbeg2, nbeg4;
    logic [31:0] fdo2, fdo4;
    logic [19:0] fso2, fso4;
    logic        clko2, clko4;

    int n_pass  = 0;
    int n_total = 0;

    // Reference state: loaded frames plus captured S_END history
    // (hist[0] = sample taken at the most recent live edge).
    logic [31:0] m_frame [NF];
    logic [51:0] hist [$];

    always #5 clk = ~clk;

    term_loopback_cfg #(.PIPE_DEPTH(2)) dut2 (
        .UserCLK(clk), .resetn(resetn), .S_END(s_end), .N_BEG(nbeg2),
        .FrameData(fdata), .FrameData_O(fdo2), .FrameStrobe(fstb),
        .FrameStrobe_O(fso2), .UserCLKo(clko2)
    );

    term_loopback_cfg #(.PIPE_DEPTH(4)) dut4 (
        .UserCLK(clk), .resetn(resetn), .S_END(s_end), .N_BEG(nbeg4),
        .FrameData(fdata), .FrameData_O(fdo4), .FrameStrobe(fstb),
        .FrameStrobe_O(fso4), .UserCLKo(clko4)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [51:0] model_nbeg(input int d);
        logic [127:0] flat;
        logic [51:0]  r;
        int           m;
        flat = {m_frame[3], m_frame[2], m_frame[1], m_frame[0]};
        r    = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            m = int'((flat >> (2 * c)) & 128'd3);
            if (m == 1)      r[c] = s_end[c];
            else if (m == 2) r[c] = hist[d-1][c];
            else if (m == 3) r[c] = 1'b1;
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int f = 0; f < NF; f++) m_frame[f] = '0;
        hist.delete();
        for (int i = 0; i < 4; i++) hist.push_back('0);
    endtask

    task automatic model_edge();
        if (resetn) begin
            for (int f = 0; f < NF; f++)
                if (fstb[f]) m_frame[f] = fdata;
            hist.push_front(s_end);
            void'(hist.pop_back());
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "/nbeg_d2"}, nbeg2, model_nbeg(2));
        chk({tag, "/nbeg_d4"}, nbeg4, model_nbeg(4));
        chk({tag, "/strobe_o"}, fso2, fstb);
        chk({tag, "/data_o"}, fdo4, fdata);
        chk({tag, "/clk_o"}, {clko2, clko4}, {clk, clk});
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(tag);
    endtask

    task automatic write_frames(input logic [19:0] mask, input logic [31:0] data, input string tag);
        fstb  = mask;
        fdata = data;
        step(tag);
        fstb  = '0;
    endtask

    task automatic rand_s_end();
        logic [63:0] t;
        t     = {$urandom(), $urandom()};
        s_end = t[51:0];
    endtask

    initial begin
        resetn = 1'b0;
        s_end  = '1;
        fstb   = '0;
        fdata  = '0;
        model_reset();

        // Reset then idle
        #2 check_outputs("reset_async");
        step("reset_hold");
        fstb = 20'h5A5A5;
        step("reset_strobe_pass");
        fstb = '0;
        #2 resetn = 1'b1;
        for (int i = 0; i < 3; i++) step("idle_after_reset");
        chk("idle_zero", nbeg2, 52'd0);

        // Direct mode
        write_frames(20'hF, 32'h55555555, "load_direct");
        s_end = 52'hA5A5A5A5A5A52;
        #1 check_outputs("direct");
        s_end[51] = ~s_end[51];
        #1 check_outputs("direct_toggle51");
        chk("direct_bit51", nbeg4[51], 1'b0);
        for (int i = 0; i < 4; i++) begin
            rand_s_end();
            step("direct_rand");
        end

        // Registered mode with random traffic, then an isolated pulse
        write_frames(20'hF, 32'hAAAAAAAA, "load_pipe");
        for (int i = 0; i < 10; i++) begin
            rand_s_end();
            step("pipe_rand");
        end
        s_end = '0;
        for (int i = 0; i < 5; i++) step("pipe_flush");
        s_end[7] = 1'b1;
        step("pulse_e1");
        s_end = '0;
        chk("pulse_e1", {nbeg2[7], nbeg4[7]}, 2'b00);
        step("pulse_e2");
        chk("pulse_e2", {nbeg2[7], nbeg4[7]}, 2'b10);
        step("pulse_e3");
        chk("pulse_e3", {nbeg2[7], nbeg4[7]}, 2'b00);
        step("pulse_e4");
        chk("pulse_e4", {nbeg2[7], nbeg4[7]}, 2'b01);
        step("pulse_e5");
        chk("pulse_e5", {nbeg2[7], nbeg4[7]}, 2'b00);

        // Mixed modes, then switch ch2 from direct to registered
        write_frames(20'h1, 32'h0000001B, "load_mixed");
        for (int i = 0; i < 8; i++) begin
            rand_s_end();
            s_end[1] = i[0];
            step("mixed_stream");
        end
        chk("mixed_ch0_high", nbeg2[0], 1'b1);
        chk("mixed_ch3_off", nbeg4[3], 1'b0);
        rand_s_end();
        write_frames(20'h1, 32'h0000002B, "switch_ch2");
        for (int i = 0; i < 4; i++) begin
            rand_s_end();
            step("after_switch");
        end

        // Strobe boundaries
        write_frames(20'hF, 32'h00000000, "clear_frames");
        write_frames(20'hA, 32'h55555555, "preload_1_3");
        rand_s_end();
        write_frames(20'h5, 32'hFFFFFFFF, "strobe_0_2");
        chk("strobe_0_2_lo", nbeg2[15:0], 16'hFFFF);
        chk("strobe_0_2_hi", nbeg4[47:32], 16'hFFFF);
        fstb  = 20'h80000;
        fdata = 32'h00000000;
        step("strobe19");
        chk("strobe19_pass", fso4[19], 1'b1);
        chk("strobe19_cfg", nbeg2[15:0], 16'hFFFF);
        fstb = '0;

        // Async reset mid-operation
        write_frames(20'hF, 32'hAAAAAAAA, "load_pipe2");
        for (int i = 0; i < 6; i++) begin
            rand_s_end();
            step("pipe_traffic");
        end
        #2 resetn = 1'b0;
        model_reset();
        #1 check_outputs("async_drop");
        chk("async_drop_zero", nbeg4, 52'd0);
        fstb  = 20'hF;
        fdata = 32'h55555555;
        rand_s_end();
        step("write_in_reset");
        fstb = '0;
        #2 resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rand_s_end();
            step("post_reset_idle");
        end
        chk("post_reset_zero", nbeg2, 52'd0);
        write_frames(20'hF, 32'h55555555, "reload");
        rand_s_end();
        #1 check_outputs("reload_direct");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
